pipe_stage_skid_reg: RTL and testbench

Parametrised pipeline stage register that generalises the freeze/flush stage register into an elastic two-entry skid stage with valid/ready handshakes on both sides. It sits between any two pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB) and carries one opaque DATA_W-bit payload, such as PC and instruction concatenated. It keeps one-transfer-per-cycle throughput under downstream backpressure and supports a global freeze (hazard stall) and flush (branch taken). It also reports its occupancy.

---
 rtl/pipe_stage_skid_reg.sv | 96 +++++++++
 tb/tb_pipe_stage_skid_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Elastic two-entry pipeline stage register (main + skid) with valid/ready
// handshakes on both sides, global freeze/flush, and an occupancy output.
module pipe_stage_skid_reg #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        level
);

  // Occupancy doubles as the FSM state, so level is the exposed state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  // Handshake: a beat moves on an edge only when valid and ready are both high
  // in the cycle before it; valid never depends on ready (and vice versa), and
  // both ready/valid are built purely from registered state, freeze and rst.
  assign in_ready  = ~skid_valid & ~freeze & rst;
  assign out_valid = main_valid & ~freeze;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_data;
  assign level     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= FLUSH_VAL;
      skid_data  <= FLUSH_VAL;
    end else if (flush) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= FLUSH_VAL;
      skid_data  <= FLUSH_VAL;
    end else if (!freeze) begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data  <= in_data;
            main_valid <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data <= in_data;
          end else if (in_fire) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
            state      <= FULL;
          end else if (out_fire) begin
            // main_data is left stale; only the valid bit drops.
            main_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
            state      <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed scenarios plus random traffic,
// checked against a queue-based FIFO model of the stage.
module tb_pipe_stage_skid_reg;

  localparam int                W     = 16;
  localparam logic [W-1:0]      FLUSH = 16'h5A5A;

  logic         clk;
  logic         rst;
  logic         freeze;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   level;

  pipe_stage_skid_reg #(
    .DATA_W   (W),
    .FLUSH_VAL(FLUSH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .freeze   (freeze),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .level    (level)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];   // beats the stage should hold, head = main entry
  bit           flushed;    // payload registers should read FLUSH
  int           n_vec;
  int           n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks outputs mid-cycle, then advances the model across the
  // coming edge using the (already stable) inputs.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      flushed = 1'b1;
    end else begin
      bit exp_ir;
      bit exp_ov;
      bit m_in_fire;
      bit m_out_fire;
      exp_ir = (exp_q.size() < 2) && !freeze;
      exp_ov = (exp_q.size() > 0) && !freeze;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("level", {30'd0, level}, exp_q.size());
      if (exp_q.size() > 0)
        chk("out_data", {16'd0, out_data}, {16'd0, exp_q[0]});
      else if (flushed)
        chk("out_data_flushval", {16'd0, out_data}, {16'd0, FLUSH});
      m_out_fire = exp_ov && out_ready;
      m_in_fire  = in_valid && exp_ir;
      if (m_out_fire)
        void'(exp_q.pop_front());
      if (flush) begin
        exp_q.delete();
        flushed = 1'b1;
      end else if (m_in_fire) begin
        exp_q.push_back(in_data);
        flushed = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic fr, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    freeze    = fr;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic fill2(input logic [W-1:0] a, input logic [W-1:0] b);
    drive(1'b1, a, 1'b0, 1'b0, 1'b0);
    drive(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    freeze    = 1'b0;
    flush     = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_level", {30'd0, level}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, {16'd0, FLUSH});
    exp_q.delete();
    flushed = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec     = 0;
    n_err     = 0;
    flushed   = 1'b1;
    rst       = 1'b0;
    freeze    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("init_out_valid", {31'd0, out_valid}, 32'd0);
    chk("init_in_ready", {31'd0, in_ready}, 32'd0);
    chk("init_level", {30'd0, level}, 32'd0);
    chk("init_out_data", {16'd0, out_data}, {16'd0, FLUSH});
    #10;
    rst = 1'b1;
    #1;
    chk("init_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // streaming at full rate
    drive(1'b1, 16'h0011, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h0022, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h0033, 1'b1, 1'b0, 1'b0);
    drain(2);

    // backpressure fills the skid entry, then drains in order
    fill2(16'h00A1, 16'h00A2);
    idle(1);
    drain(3);

    // freeze with both sides eager
    fill2(16'h00B1, 16'h00B2);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h00EE, 1'b1, 1'b1, 1'b0);
    drain(3);

    // flush with a simultaneous input beat
    fill2(16'h00D1, 16'h00D2);
    drive(1'b1, 16'h00C3, 1'b0, 1'b0, 1'b1);
    idle(2);

    // flush over freeze
    drive(1'b1, 16'h00E1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // asynchronous reset with the stage full
    fill2(16'h00F1, 16'h00F2);
    async_reset();
    drive(1'b1, 16'h0077, 1'b1, 1'b0, 1'b0);
    drain(2);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 99) < 70,
            W'($urandom_range(0, 16'hFFFF)),
            $urandom_range(0, 99) < 65,
            $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 3);
    end
    drain(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
